lp_serializer_scheduler: RTL and testbench
==========================================

// Module: lp_serializer_scheduler
//
// PURPOSE
//   Shares one lp_tree_serializer between NUM_REQ requesters. Each requester offers a
//   WIDTH-bit word on a valid/ready handshake. The block grants round-robin and drives the
//   granted word onto the serializer's PAR_IN for HOLD_CYCLES cycles. It then drives
//   IDLE_WORD for a guard gap before the next grant. Sits directly upstream of the serializer.
//
// PARAMETERS
//   NUM_REQ     4        number of requesters (>=2)
//   WIDTH       16       word width; matches serializer PAR_IN
//   HOLD_CYCLES 16       cycles each granted word is held on PAR_IN (>=1)
//   GAP_CYCLES  2        IDLE_WORD cycles inserted after each hold (>=0)
//   IDLE_WORD   16'h0000 value driven on PAR_IN when no word is scheduled
//
// PORTS
//   CLK         in   1                clock, all logic on rising edge
//   RESET       in   1                synchronous, active-high reset
//   REQ_VALID   in   NUM_REQ          per-requester word available
//   REQ_DATA    in   NUM_REQ*WIDTH    requester i word at [i*WIDTH +: WIDTH]
//   REQ_READY   out  NUM_REQ          one-hot accept; transfer when VALID&READY on a CLK edge
//   PAR_IN      out  WIDTH            registered word to serializer
//   GRANT_ID    out  $clog2(NUM_REQ)  index of requester whose word is on PAR_IN
//   WORD_START  out  1                1-cycle pulse, first cycle a new word is on PAR_IN
//   BUSY        out  1                1 in HOLD or GAP
//
// BEHAVIOUR
//   Reset (sync, RESET=1 at edge)
//   - State goes to IDLE. PAR_IN=IDLE_WORD, GRANT_ID=0, WORD_START=0, BUSY=0.
//   - Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
//   - REQ_READY is forced 0 while RESET=1, so no transfer occurs in a reset cycle.
//   - Reset mid-HOLD or mid-GAP aborts the current word. No partial resume.
//   States: IDLE, HOLD, GAP. The cnt register is wide enough for max(HOLD_CYCLES,GAP_CYCLES).
//   IDLE
//   - PAR_IN=IDLE_WORD.
//   - g = first i with REQ_VALID[i], searching last+1, last+2, ... (mod NUM_REQ).
//   - REQ_READY[g]=1, combinational from REQ_VALID and the state. All other bits are 0.
//   - If any VALID: PAR_IN<=REQ_DATA[g], GRANT_ID<=g, last<=g, WORD_START<=1,
//     cnt<=HOLD_CYCLES-1, state<=HOLD.
//   - Otherwise stay in IDLE.
//   HOLD
//   - REQ_READY=0, BUSY=1, PAR_IN holds its value. WORD_START=1 only in the first HOLD cycle.
//   - cnt>0: cnt<=cnt-1.
//   - cnt==0 and GAP_CYCLES>0: PAR_IN<=IDLE_WORD, cnt<=GAP_CYCLES-1, state<=GAP.
//   - cnt==0 and GAP_CYCLES==0: PAR_IN<=IDLE_WORD, state<=IDLE.
//   GAP
//   - REQ_READY=0, BUSY=1, PAR_IN=IDLE_WORD. Counts down like HOLD.
//   - At cnt==0: state<=IDLE.
//   Timing
//   - Latency: accepted in cycle t -> on PAR_IN during cycles t+1 .. t+HOLD_CYCLES.
//   - Minimum word period is HOLD_CYCLES+GAP_CYCLES+1. IDLE always lasts >=1 cycle.
//   Handshake
//   - A requester holds REQ_DATA stable while VALID=1 and READY=0.
//   - VALID may drop before a grant. Nothing is committed until VALID&READY.
//   - The requester must not change REQ_DATA in the accept cycle.
//   Arbitration
//   - Simultaneous requests are served strictly in rotation.
//   - A requester that stays VALID waits at most NUM_REQ-1 words.
//   - The pointer wraps from NUM_REQ-1 to 0.
//   GRANT_ID is held until the next grant. It is meaningful only while BUSY=1.
//
// TESTING (defaults, 100-unit CLK period)
//   1 RESET=1 for 2 cycles with all VALID=1 -> READY=0, PAR_IN=0, BUSY=0 throughout reset.
//   2 VALID[0]=1, DATA0=16'hC5AF accepted at cycle t
//     -> READY[0]=1 at t; WORD_START=1 at t+1; PAR_IN=C5AF during t+1..t+16;
//        PAR_IN=0 and BUSY=1 during t+17..t+18; IDLE at t+19.
//   3 All four VALID with DATA=A000,A001,A002,A003 held -> grant order 0,1,2,3,0.
//     WORD_START pulses are 19 cycles apart. GRANT_ID matches each word.
//   4 Only VALID[1] and VALID[3] held -> PAR_IN alternates DATA1, DATA3, DATA1.
//     READY is never asserted to 0 or 2.
//   5 RESET=1 for 1 cycle at the 6th HOLD cycle of requester 2's word
//     -> next cycle PAR_IN=0, IDLE. With 0 and 2 both VALID, requester 0 is granted next.
//   6 VALID[2] pulsed 1 cycle during HOLD, then dropped -> never granted; PAR_IN stays 0 after GAP.

Source files
------------

// File: rtl/lp_serializer_scheduler.sv
// Round-robin scheduler that shares one tree serializer between NUM_REQ requesters.
// Each granted word is held on PAR_IN for HOLD_CYCLES, followed by GAP_CYCLES of IDLE_WORD.
module lp_serializer_scheduler #(
    parameter int               NUM_REQ     = 4,
    parameter int               WIDTH       = 16,
    parameter int               HOLD_CYCLES = 16,
    parameter int               GAP_CYCLES  = 2,
    parameter logic [WIDTH-1:0] IDLE_WORD   = '0,
    localparam int              ID_W        = $clog2(NUM_REQ)
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [NUM_REQ-1:0]       REQ_VALID,
    input  logic [NUM_REQ*WIDTH-1:0] REQ_DATA,
    output logic [NUM_REQ-1:0]       REQ_READY,
    output logic [WIDTH-1:0]         PAR_IN,
    output logic [ID_W-1:0]          GRANT_ID,
    output logic                     WORD_START,
    output logic                     BUSY
);

    localparam int MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_GAP} state_t;

    state_t                         state;
    logic [CNT_W-1:0]               cnt;
    logic [ID_W-1:0]                last;
    logic [NUM_REQ-1:0][WIDTH-1:0]  req_word;
    logic                           gnt_any;
    logic [ID_W-1:0]                gnt_idx;
    logic [ID_W-1:0]                cand;

    genvar i;
    generate
        for (i = 0; i < NUM_REQ; i++) begin : g_unpack
            assign req_word[i] = REQ_DATA[i*WIDTH +: WIDTH];
        end
    endgenerate

    // Search starts one past the last grant, so the most recent winner has lowest priority.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(last) + k) % NUM_REQ);
            if (!gnt_any && REQ_VALID[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        REQ_READY = '0;
        if (!RESET && state == ST_IDLE && gnt_any)
            REQ_READY[gnt_idx] = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            last       <= ID_W'(NUM_REQ - 1);
            PAR_IN     <= IDLE_WORD;
            GRANT_ID   <= '0;
            WORD_START <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            WORD_START <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (gnt_any) begin
                        PAR_IN     <= req_word[gnt_idx];
                        GRANT_ID   <= gnt_idx;
                        last       <= gnt_idx;
                        WORD_START <= 1'b1;
                        BUSY       <= 1'b1;
                        cnt        <= CNT_W'(HOLD_CYCLES - 1);
                        state      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        PAR_IN <= IDLE_WORD;
                        if (GAP_CYCLES > 0) begin
                            cnt   <= CNT_W'(GAP_CYCLES - 1);
                            state <= ST_GAP;
                        end else begin
                            BUSY  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        BUSY  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lp_serializer_scheduler.sv
// Bench for lp_serializer_scheduler: a per-cycle schedule model (grant time -> hold/gap windows),
// a table of single-grant vectors, directed multi-cycle sequences and randomized traffic.
module tb_lp_serializer_scheduler;

    localparam int N = 4;
    localparam int W = 16;
    localparam int H = 16;
    localparam int G = 2;
    localparam logic [W-1:0] IDLE = 16'h0000;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   valid;
    logic [N*W-1:0] data;
    logic [N-1:0]   ready;
    logic [W-1:0]   par_in;
    logic [1:0]     gid;
    logic           ws;
    logic           busy;

    always #50 clk = ~clk;

    lp_serializer_scheduler #(
        .NUM_REQ(N), .WIDTH(W), .HOLD_CYCLES(H), .GAP_CYCLES(G), .IDLE_WORD(IDLE)
    ) dut (
        .CLK(clk), .RESET(rst), .REQ_VALID(valid), .REQ_DATA(data), .REQ_READY(ready),
        .PAR_IN(par_in), .GRANT_ID(gid), .WORD_START(ws), .BUSY(busy)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    // Model: a grant at cycle c owns PAR_IN for c+1..c+H and keeps BUSY through c+H+G.
    int           m_start    = -100;
    int           m_hold_end = -100;
    int           m_busy_end = -100;
    logic [W-1:0] m_data     = '0;
    int           m_id       = 0;
    int           m_last     = N - 1;
    bit           m_init     = 0;

    int           ws_q[$];
    int           gid_q[$];
    logic [W-1:0] word_q[$];
    logic [N-1:0] rdy_or;

    typedef struct {
        logic [N-1:0] v;
        logic [N-1:0] rdy;
        int           gid;
        logic         ws;
        logic [W-1:0] par;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    endtask

    function automatic int pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    function automatic logic [N*W-1:0] pack4(input logic [W-1:0] d0, input logic [W-1:0] d1,
                                             input logic [W-1:0] d2, input logic [W-1:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    // One clock cycle: compare against the model mid-cycle, advance the model, take the edge.
    task automatic step();
        int           g;
        bit           idle;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        idle    = cyc > m_busy_end;
        g       = pick(valid, m_last);
        exp_rdy = (idle && !rst && g >= 0) ? (N'(1) << g) : '0;
        chk("ready", W'(ready), W'(exp_rdy));
        if (m_init) begin
            chk("par_in", par_in, (cyc >= m_start && cyc <= m_hold_end) ? m_data : IDLE);
            chk("busy", W'(busy), W'(!idle));
            chk("word_start", W'(ws), W'(cyc == m_start));
            if (!idle) chk("grant_id", W'(gid), W'(m_id));
        end
        if (ws) begin
            ws_q.push_back(cyc);
            gid_q.push_back(int'(gid));
            word_q.push_back(par_in);
        end
        rdy_or |= ready;
        if (rst) begin
            m_init = 1; m_start = -100; m_hold_end = cyc; m_busy_end = cyc;
            m_id = 0; m_last = N - 1;
        end else if (exp_rdy != '0) begin
            m_start = cyc + 1; m_hold_end = cyc + H; m_busy_end = cyc + H + G;
            m_data = data[g*W +: W]; m_id = g; m_last = g;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        ws_q.delete(); gid_q.delete(); word_q.delete();
        rdy_or = '0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        int t;
        tbl[0] = '{4'b0001, 4'b0001, 0, 1'b1, 16'hA000};
        tbl[1] = '{4'b0010, 4'b0010, 1, 1'b1, 16'hA001};
        tbl[2] = '{4'b0100, 4'b0100, 2, 1'b1, 16'hA002};
        tbl[3] = '{4'b1000, 4'b1000, 3, 1'b1, 16'hA003};
        tbl[4] = '{4'b1010, 4'b0010, 1, 1'b1, 16'hA001};
        tbl[5] = '{4'b1100, 4'b0100, 2, 1'b1, 16'hA002};
        tbl[6] = '{4'b1111, 4'b0001, 0, 1'b1, 16'hA000};
        tbl[7] = '{4'b0000, 4'b0000, 0, 1'b0, 16'h0000};

        rst = 1'b1; valid = '1; data = pack4(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        rdy_or = '0;
        @(posedge clk); #1;
        // Two reset cycles with every requester valid.
        step(); step();
        rst = 1'b0; valid = '0;
        #1;
        chk("rst_par_in", par_in, IDLE);
        chk("rst_busy", W'(busy), 16'd0);
        chk("rst_gid", W'(gid), 16'd0);
        chk("rst_ready", W'(ready), 16'd0);
        step();

        // Single grant from a freshly reset pointer.
        for (int i = 0; i < 8; i++) begin
            do_reset();
            valid = tbl[i].v;
            data  = pack4(16'hA000, 16'hA001, 16'hA002, 16'hA003);
            #1;
            chk("tbl_ready", W'(ready), W'(tbl[i].rdy));
            step();
            valid = '0;
            #1;
            chk("tbl_gid", W'(gid), W'(tbl[i].gid));
            chk("tbl_ws", W'(ws), W'(tbl[i].ws));
            chk("tbl_par", par_in, tbl[i].par);
        end

        // Single word latency and gap.
        do_reset();
        valid = 4'b0001; data = pack4(16'hC5AF, 16'h0, 16'h0, 16'h0);
        t = cyc;
        step();
        valid = '0;
        run(24);
        chk("s2_ws_cycle", W'(ws_q.size() > 0 ? ws_q[0] - t : -1), 16'd1);
        chk("s2_word", word_q.size() > 0 ? word_q[0] : 16'hFFFF, 16'hC5AF);

        // All four requesting: strict rotation and 19-cycle word period.
        do_reset();
        valid = 4'b1111; data = pack4(16'hA000, 16'hA001, 16'hA002, 16'hA003);
        run(96);
        if (gid_q.size() < 5) chk("s3_count", W'(gid_q.size()), 16'd5);
        else for (int k = 0; k < 5; k++) begin
            chk("s3_gid", W'(gid_q[k]), W'(k % 4));
            chk("s3_word", word_q[k], 16'hA000 + W'(k % 4));
            if (k > 0) chk("s3_period", W'(ws_q[k] - ws_q[k-1]), 16'd19);
        end

        // Requesters 1 and 3 only.
        do_reset();
        valid = 4'b1010; data = pack4(16'h0, 16'hB111, 16'h0, 16'hB333);
        run(58);
        chk("s4_ready_seen", W'(rdy_or), 16'b1010);
        if (word_q.size() < 3) chk("s4_count", W'(word_q.size()), 16'd3);
        else begin
            chk("s4_w0", word_q[0], 16'hB111);
            chk("s4_w1", word_q[1], 16'hB333);
            chk("s4_w2", word_q[2], 16'hB111);
        end

        // Reset at the 6th HOLD cycle of requester 2.
        do_reset();
        valid = 4'b0100; data = pack4(16'hD000, 16'h0, 16'hD222, 16'h0);
        step();
        valid = 4'b0101;
        run(5);
        chk("s5_pre_par", par_in, 16'hD222);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("s5_par_idle", par_in, IDLE);
        chk("s5_busy", W'(busy), 16'd0);
        chk("s5_ready", W'(ready), 16'b0001);
        step(); step();
        chk("s5_next_gid", W'(gid), 16'd0);
        chk("s5_next_par", par_in, 16'hD000);

        // VALID[2] pulsed during HOLD is never granted.
        do_reset();
        valid = 4'b0001; data = pack4(16'hD00D, 16'h0, 16'hEEEE, 16'h0);
        step();
        valid = '0;
        run(3);
        valid = 4'b0100;
        step();
        valid = '0;
        run(30);
        chk("s6_words", W'(ws_q.size()), 16'd1);
        chk("s6_par", par_in, IDLE);
        chk("s6_busy", W'(busy), 16'd0);

        // Randomized traffic with occasional resets.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            rst   = ($urandom_range(0, 299) == 0);
            valid = ($urandom_range(0, 1) == 1) ? N'($urandom) : N'($urandom & $urandom);
            data  = {$urandom, $urandom};
            step();
        end
        rst = 1'b0; valid = '0;
        run(25);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
